// File: rtl/vector_axi_read_master.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// vector_axi_read_master
// Reads a contiguous block of memory over an AXI4 read channel and forwards
// every returned beat onto a ready/valid stream. The transfer is cut into
// bursts of at most MAX_BURST_LEN beats, and no burst crosses a 4 KB page.
// Only one burst is outstanding at a time.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   ctrl_start                one-cycle start pulse (ignored unless idle)
//   ctrl_addr_offset          byte start address, aligned to a beat
//   ctrl_xfer_size_in_bytes   byte count, a multiple of the beat size
//   ctrl_busy                 high while bursts are being issued/received
//   ctrl_done                 one-cycle pulse after the final beat
//   v_m_axi_ar*               AXI read-address channel (arvalid/ready/addr/len)
//   v_m_axi_r*                AXI read-data channel (rvalid/ready/data/last)
//   rd_t*                     output stream; rd_tlast marks the last beat
// ---------------------------------------------------------------------------
module vector_axi_read_master #(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_XFER_SIZE_WIDTH  = 32,
   parameter int MAX_BURST_LEN      = 16
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          ctrl_start,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
   input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
   output logic                          ctrl_busy,
   output logic                          ctrl_done,
   output logic                          v_m_axi_arvalid,
   input  logic                          v_m_axi_arready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] v_m_axi_araddr,
   output logic [7:0]                    v_m_axi_arlen,
   input  logic                          v_m_axi_rvalid,
   output logic                          v_m_axi_rready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] v_m_axi_rdata,
   input  logic                          v_m_axi_rlast,
   output logic                          rd_tvalid,
   input  logic                          rd_tready,
   output logic [C_M_AXI_DATA_WIDTH-1:0] rd_tdata,
   output logic                          rd_tlast
);

   localparam int BPB      = C_M_AXI_DATA_WIDTH / 8;
   localparam int BPB_LOG2 = $clog2(BPB);
   localparam int CW       = (C_XFER_SIZE_WIDTH > 13) ? C_XFER_SIZE_WIDTH : 13;
   localparam logic [C_XFER_SIZE_WIDTH-1:0] ONE_BEAT = C_XFER_SIZE_WIDTH'(1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   state_t                        state;
   logic [C_M_AXI_ADDR_WIDTH-1:0] addr;
   logic [C_XFER_SIZE_WIDTH-1:0]  beats_left;
   logic [8:0]                    len;

   logic                          beat_accepted;
   logic [C_XFER_SIZE_WIDTH-1:0]  xfer_beats;
   logic [C_XFER_SIZE_WIDTH-1:0]  beats_after;
   logic [C_M_AXI_ADDR_WIDTH-1:0] next_addr;
   logic [8:0]                    start_len;
   logic [8:0]                    next_len;

   // Burst length is the smallest of the configured maximum, the beats still
   // owed, and the beats left before the next 4 KB page boundary.
   function automatic logic [8:0] calc_len(input logic [11:0] addr_low,
                                           input logic [C_XFER_SIZE_WIDTH-1:0] beats);
      logic [12:0]   bytes_to_4k;
      logic [CW-1:0] beats_to_4k;
      logic [CW-1:0] limit;
      bytes_to_4k = 13'h1000 - {1'b0, addr_low};
      beats_to_4k = CW'(bytes_to_4k >> BPB_LOG2);
      limit       = CW'(MAX_BURST_LEN);
      if (CW'(beats) < limit) limit = CW'(beats);
      if (beats_to_4k < limit) limit = beats_to_4k;
      return limit[8:0];
   endfunction

   // The data channel is a straight pass-through while a burst is in flight;
   // outside DATA the slave is never allowed to hand over a beat.
   assign v_m_axi_rready = (state == DATA) && rd_tready;
   assign rd_tvalid      = (state == DATA) && v_m_axi_rvalid;
   assign rd_tdata       = v_m_axi_rdata;
   assign rd_tlast       = rd_tvalid && (beats_left == ONE_BEAT);
   assign beat_accepted  = v_m_axi_rvalid && v_m_axi_rready;

   // Beat count saturates at zero so a slave that sends more beats than
   // requested cannot wrap the counter; the burst still ends on rlast.
   assign xfer_beats  = ctrl_xfer_size_in_bytes >> BPB_LOG2;
   assign beats_after = (beats_left != '0) ? beats_left - ONE_BEAT : '0;
   assign next_addr   = addr + (C_M_AXI_ADDR_WIDTH'(len) << BPB_LOG2);
   assign start_len   = calc_len(ctrl_addr_offset[11:0], xfer_beats);
   assign next_len    = calc_len(next_addr[11:0], beats_after);

   // Transfer sequencer. The AR outputs are registered and loaded on the same
   // edge that enters ADDR, so arvalid appears the cycle after the request
   // and stays put until the slave accepts it. A burst ends on rlast only,
   // then either the next burst is issued or the transfer completes.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state           <= IDLE;
         addr            <= '0;
         beats_left      <= '0;
         len             <= '0;
         v_m_axi_arvalid <= 1'b0;
         v_m_axi_araddr  <= '0;
         v_m_axi_arlen   <= '0;
         ctrl_busy       <= 1'b0;
         ctrl_done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ctrl_done <= 1'b0;
               if (ctrl_start) begin
                  if (xfer_beats != '0) begin
                     addr            <= ctrl_addr_offset;
                     beats_left      <= xfer_beats;
                     len             <= start_len;
                     v_m_axi_arvalid <= 1'b1;
                     v_m_axi_araddr  <= ctrl_addr_offset;
                     v_m_axi_arlen   <= 8'(start_len - 9'd1);
                     ctrl_busy       <= 1'b1;
                     state           <= ADDR;
                  end else begin
                     ctrl_done <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            ADDR: begin
               if (v_m_axi_arready) begin
                  v_m_axi_arvalid <= 1'b0;
                  state           <= DATA;
               end
            end
            DATA: begin
               if (beat_accepted) begin
                  beats_left <= beats_after;
                  if (v_m_axi_rlast) begin
                     addr <= next_addr;
                     if (beats_after != '0) begin
                        len             <= next_len;
                        v_m_axi_arvalid <= 1'b1;
                        v_m_axi_araddr  <= next_addr;
                        v_m_axi_arlen   <= 8'(next_len - 9'd1);
                        state           <= ADDR;
                     end else begin
                        ctrl_busy <= 1'b0;
                        ctrl_done <= 1'b1;
                        state     <= DONE;
                     end
                  end
               end
            end
            DONE: begin
               ctrl_done <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vector_axi_read_master.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_vector_axi_read_master
// Directed bench for vector_axi_read_master with default parameters
// (32-bit address/data, 4 bytes per beat, 16-beat maximum burst).
// A small AXI slave returns the byte address of each beat as its data, a
// stream consumer drives rd_tready, and a monitor logs AR handshakes,
// stream beats and ctrl_done pulses for the main sequence to check.
// ---------------------------------------------------------------------------
module tb_vector_axi_read_master;

   logic        clk;
   logic        rstn;
   logic        ctrl_start;
   logic [31:0] ctrl_addr_offset;
   logic [31:0] ctrl_xfer_size_in_bytes;
   logic        ctrl_busy;
   logic        ctrl_done;
   logic        v_m_axi_arvalid;
   logic        v_m_axi_arready;
   logic [31:0] v_m_axi_araddr;
   logic [7:0]  v_m_axi_arlen;
   logic        v_m_axi_rvalid;
   logic        v_m_axi_rready;
   logic [31:0] v_m_axi_rdata;
   logic        v_m_axi_rlast;
   logic        rd_tvalid;
   logic        rd_tready;
   logic [31:0] rd_tdata;
   logic        rd_tlast;

   int compared   = 0;
   int mismatched = 0;

   int ar_stall    = 0;
   bit toggle_mode = 1'b0;

   logic [31:0] ar_addr_q[$];
   logic [7:0]  ar_len_q[$];
   logic [31:0] beat_data_q[$];
   logic        beat_last_q[$];
   int          cyc           = 0;
   int          last_beat_cyc = 0;
   int          done_cyc      = 0;
   int          done_cnt      = 0;
   int          rready_viol   = 0;

   vector_axi_read_master dut (
      .clk                     (clk),
      .rstn                    (rstn),
      .ctrl_start              (ctrl_start),
      .ctrl_addr_offset        (ctrl_addr_offset),
      .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
      .ctrl_busy               (ctrl_busy),
      .ctrl_done               (ctrl_done),
      .v_m_axi_arvalid         (v_m_axi_arvalid),
      .v_m_axi_arready         (v_m_axi_arready),
      .v_m_axi_araddr          (v_m_axi_araddr),
      .v_m_axi_arlen           (v_m_axi_arlen),
      .v_m_axi_rvalid          (v_m_axi_rvalid),
      .v_m_axi_rready          (v_m_axi_rready),
      .v_m_axi_rdata           (v_m_axi_rdata),
      .v_m_axi_rlast           (v_m_axi_rlast),
      .rd_tvalid               (rd_tvalid),
      .rd_tready               (rd_tready),
      .rd_tdata                (rd_tdata),
      .rd_tlast                (rd_tlast)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // AXI slave: accepts one AR at a time after ar_stall cycles of arvalid,
   // then streams arlen+1 beats whose data is the beat's byte address.
   // It is cleared asynchronously together with the DUT.
   initial begin : axiSlave
      logic [31:0] s_addr;
      int          s_beats;
      bit          s_active;
      int          ar_wait;
      s_addr = '0; s_beats = 0; s_active = 1'b0; ar_wait = 0;
      v_m_axi_arready = 1'b0; v_m_axi_rvalid = 1'b0;
      v_m_axi_rdata = '0; v_m_axi_rlast = 1'b0;
      forever begin
         @(posedge clk or negedge rstn);
         if (!rstn) begin
            s_addr = '0; s_beats = 0; s_active = 1'b0; ar_wait = 0;
            v_m_axi_arready = 1'b0; v_m_axi_rvalid = 1'b0;
            v_m_axi_rdata = '0; v_m_axi_rlast = 1'b0;
         end else begin
            if (v_m_axi_rvalid && v_m_axi_rready) begin
               s_addr  = s_addr + 32'd4;
               s_beats = s_beats - 1;
               if (s_beats == 0) s_active = 1'b0;
            end
            if (v_m_axi_arvalid && v_m_axi_arready) begin
               s_addr   = v_m_axi_araddr;
               s_beats  = int'(v_m_axi_arlen) + 1;
               s_active = 1'b1;
               ar_wait  = 0;
            end
            #1;
            if (rstn) begin
               if (v_m_axi_arvalid && !s_active) begin
                  ar_wait         = ar_wait + 1;
                  v_m_axi_arready = (ar_wait > ar_stall);
               end else begin
                  v_m_axi_arready = 1'b0;
               end
               v_m_axi_rvalid = s_active;
               v_m_axi_rdata  = s_addr;
               v_m_axi_rlast  = s_active && (s_beats == 1);
            end
         end
      end
   end

   // Stream consumer: always ready, or alternating 1/0 in toggle mode.
   initial begin : streamConsumer
      rd_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         rd_tready = toggle_mode ? ~rd_tready : 1'b1;
      end
   end

   // Monitor: samples mid-cycle, logging what will handshake on the next edge.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rstn) begin
            if (v_m_axi_arvalid && v_m_axi_arready) begin
               ar_addr_q.push_back(v_m_axi_araddr);
               ar_len_q.push_back(v_m_axi_arlen);
            end
            if (rd_tvalid && rd_tready) begin
               beat_data_q.push_back(rd_tdata);
               beat_last_q.push_back(rd_tlast);
               last_beat_cyc = cyc;
            end
            if (ctrl_done) begin
               done_cnt = done_cnt + 1;
               done_cyc = cyc;
            end
            if (v_m_axi_rready && !rd_tready) rready_viol = rready_viol + 1;
            if (rd_tvalid && rd_tready && !v_m_axi_rready) rready_viol = rready_viol + 1;
         end
         cyc = cyc + 1;
      end
   end

   // Absolute time limit so the run can never hang.
   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: observed=running expected=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      compared = compared + 1;
      assert (observed === expected) else begin
         mismatched = mismatched + 1;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic nextCycle();
      @(negedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic [31:0] offset, input logic [31:0] size);
      ctrl_start              = 1'b1;
      ctrl_addr_offset        = offset;
      ctrl_xfer_size_in_bytes = size;
      nextCycle();
      ctrl_start = 1'b0;
   endtask

   task automatic waitDone(input string tag);
      int n = 0;
      while (ctrl_done !== 1'b1 && n < 3000) begin
         nextCycle();
         n++;
      end
      checkOutput(tag, 64'(ctrl_done), 64'(1));
      nextCycle();
   endtask

   task automatic checkAr(input string tag, input int idx,
                          input logic [31:0] addr, input logic [7:0] len);
      checkOutput({tag, "_araddr"},
                  (idx < ar_addr_q.size()) ? 64'(ar_addr_q[idx]) : 64'hDEAD_DEAD, 64'(addr));
      checkOutput({tag, "_arlen"},
                  (idx < ar_len_q.size()) ? 64'(ar_len_q[idx]) : 64'hDEAD_DEAD, 64'(len));
   endtask

   task automatic checkBeats(input string tag, input int first, input int count,
                             input logic [31:0] base);
      int bad = 0;
      checkOutput({tag, "_beat_count"}, 64'(beat_data_q.size() - first), 64'(count));
      for (int i = 0; i < count && first + i < beat_data_q.size(); i++) begin
         if (beat_data_q[first + i] !== base + 32'(4 * i)) bad++;
         if (beat_last_q[first + i] !== (i == count - 1)) bad++;
      end
      checkOutput({tag, "_beat_content"}, 64'(bad), 64'(0));
   endtask

   initial begin : mainSequence
      int ia, ib, d0, bad, n;
      ctrl_start = 1'b0; ctrl_addr_offset = '0; ctrl_xfer_size_in_bytes = '0;
      rstn = 1'b1;
      #1 rstn = 1'b0;
      repeat (3) nextCycle();

      $display("[TB] reset values");
      checkOutput("rst_flags", 64'({v_m_axi_arvalid, v_m_axi_rready, rd_tvalid, rd_tlast,
                                    ctrl_busy, ctrl_done}), 64'(0));
      checkOutput("rst_araddr", 64'(v_m_axi_araddr), 64'(0));
      checkOutput("rst_arlen", 64'(v_m_axi_arlen), 64'(0));
      rstn = 1'b1;
      repeat (2) nextCycle();

      $display("[TB] single burst 0x1000 / 64 bytes");
      ia = ar_addr_q.size(); ib = beat_data_q.size(); d0 = done_cnt;
      applyStimulus(32'h1000, 32'd64);
      checkOutput("c1_arvalid_latency", 64'(v_m_axi_arvalid), 64'(1));
      checkOutput("c1_busy", 64'(ctrl_busy), 64'(1));
      waitDone("c1_done");
      checkOutput("c1_ar_count", 64'(ar_addr_q.size() - ia), 64'(1));
      checkAr("c1_ar0", ia, 32'h1000, 8'd15);
      checkBeats("c1", ib, 16, 32'h1000);
      checkOutput("c1_done_latency", 64'(done_cyc - last_beat_cyc), 64'(1));
      checkOutput("c1_done_pulses", 64'(done_cnt - d0), 64'(1));
      checkOutput("c1_idle_flags", 64'({ctrl_busy, ctrl_done}), 64'(0));

      $display("[TB] multi burst 0x0 / 160 bytes");
      ia = ar_addr_q.size(); ib = beat_data_q.size();
      applyStimulus(32'h0, 32'd160);
      waitDone("c2_done");
      checkOutput("c2_ar_count", 64'(ar_addr_q.size() - ia), 64'(3));
      checkAr("c2_ar0", ia, 32'h0, 8'd15);
      checkAr("c2_ar1", ia + 1, 32'h40, 8'd15);
      checkAr("c2_ar2", ia + 2, 32'h80, 8'd7);
      checkBeats("c2", ib, 40, 32'h0);

      $display("[TB] 4 KB split 0x0FF8 / 32 bytes");
      ia = ar_addr_q.size(); ib = beat_data_q.size();
      applyStimulus(32'h0FF8, 32'd32);
      waitDone("c3_done");
      checkOutput("c3_ar_count", 64'(ar_addr_q.size() - ia), 64'(2));
      checkAr("c3_ar0", ia, 32'h0FF8, 8'd1);
      checkAr("c3_ar1", ia + 1, 32'h1000, 8'd5);
      checkBeats("c3", ib, 8, 32'h0FF8);

      $display("[TB] zero size");
      ia = ar_addr_q.size();
      applyStimulus(32'h500, 32'd0);
      checkOutput("c4_done_arvalid_busy",
                  64'({ctrl_done, v_m_axi_arvalid, ctrl_busy}), 64'(3'b100));
      nextCycle();
      checkOutput("c4_done_cleared", 64'(ctrl_done), 64'(0));
      checkOutput("c4_no_ar", 64'(ar_addr_q.size() - ia), 64'(0));

      $display("[TB] stream backpressure 0x200 / 48 bytes");
      ia = ar_addr_q.size(); ib = beat_data_q.size(); d0 = rready_viol;
      toggle_mode = 1'b1;
      applyStimulus(32'h200, 32'd48);
      waitDone("c5_done");
      toggle_mode = 1'b0;
      checkAr("c5_ar0", ia, 32'h200, 8'd11);
      checkBeats("c5", ib, 12, 32'h200);
      checkOutput("c5_rready_tracks_tready", 64'(rready_viol - d0), 64'(0));

      $display("[TB] arready stall and start while busy");
      ia = ar_addr_q.size(); ib = beat_data_q.size(); d0 = done_cnt;
      ar_stall = 5;
      applyStimulus(32'h300, 32'd16);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if ({v_m_axi_arvalid, v_m_axi_araddr, v_m_axi_arlen} !== {1'b1, 32'h300, 8'd3}) bad++;
         if (i == 1) begin
            ctrl_start = 1'b1; ctrl_addr_offset = 32'h800; ctrl_xfer_size_in_bytes = 32'd4;
         end
         if (i == 2) ctrl_start = 1'b0;
         nextCycle();
      end
      checkOutput("c6_ar_stable", 64'(bad), 64'(0));
      waitDone("c6_done");
      repeat (5) nextCycle();
      ar_stall = 0;
      checkOutput("c6_ar_count", 64'(ar_addr_q.size() - ia), 64'(1));
      checkAr("c6_ar0", ia, 32'h300, 8'd3);
      checkBeats("c6", ib, 4, 32'h300);
      checkOutput("c6_done_pulses", 64'(done_cnt - d0), 64'(1));

      $display("[TB] reset mid-transfer");
      applyStimulus(32'h400, 32'd64);
      n = 0;
      while (rd_tvalid !== 1'b1 && n < 100) begin
         nextCycle();
         n++;
      end
      checkOutput("c7_reached_data", 64'(rd_tvalid), 64'(1));
      repeat (3) nextCycle();
      d0 = done_cnt;
      #1 rstn = 1'b0;
      #1;
      checkOutput("c7_rst_flags", 64'({v_m_axi_arvalid, v_m_axi_rready, rd_tvalid, rd_tlast,
                                       ctrl_busy, ctrl_done}), 64'(0));
      checkOutput("c7_rst_araddr", 64'(v_m_axi_araddr), 64'(0));
      checkOutput("c7_rst_arlen", 64'(v_m_axi_arlen), 64'(0));
      repeat (2) nextCycle();
      rstn = 1'b1;
      repeat (20) nextCycle();
      checkOutput("c7_no_done", 64'(done_cnt - d0), 64'(0));
      checkOutput("c7_not_busy", 64'(ctrl_busy), 64'(0));

      ia = ar_addr_q.size(); ib = beat_data_q.size();
      applyStimulus(32'h40, 32'd8);
      waitDone("c7_recover_done");
      checkAr("c7_recover_ar0", ia, 32'h40, 8'd1);
      checkBeats("c7_recover", ib, 2, 32'h40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/vector_axi_read_master.md
VECTOR_AXI_READ_MASTER -- requirements
Module: vector_axi_read_master

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rstn; every other input is sampled on the rising edge of clk.
REQ-002 Parameter C_M_AXI_ADDR_WIDTH, default 32, SHALL set the AXI address width.
REQ-003 Parameter C_M_AXI_DATA_WIDTH, default 32, SHALL set the AXI/stream data width; BPB = C_M_AXI_DATA_WIDTH/8 is the number of bytes per beat.
REQ-004 Parameter C_XFER_SIZE_WIDTH, default 32, SHALL set the width of the byte-count input.
REQ-005 Parameter MAX_BURST_LEN, default 16, range 1..256, SHALL set the maximum number of beats per AXI burst.
REQ-006 Ports SHALL be as follows:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- ctrl_start  in  1  one-cycle start pulse
- ctrl_addr_offset  in  ADDR_W  byte start address, BPB-aligned
- ctrl_xfer_size_in_bytes  in  XFER_W  byte count, multiple of BPB
- ctrl_busy  out  1  transfer in progress
- ctrl_done  out  1  one-cycle completion pulse
- v_m_axi_arvalid  out  1  AR valid
- v_m_axi_arready  in  1  AR ready
- v_m_axi_araddr  out  ADDR_W  burst address
- v_m_axi_arlen  out  8  beats-1
- v_m_axi_rvalid  in  1  R valid
- v_m_axi_rready  out  1  R ready
- v_m_axi_rdata  in  DATA_W  R data
- v_m_axi_rlast  in  1  R last of burst
- rd_tvalid  out  1  stream valid
- rd_tready  in  1  stream ready
- rd_tdata  out  DATA_W  stream data
- rd_tlast  out  1  final beat of whole transfer

Function
REQ-007 The FSM SHALL have the states IDLE, ADDR, DATA and DONE.
REQ-008 In IDLE, ctrl_start=1 with a nonzero size SHALL latch addr = offset and beats_left = size/BPB, and move to ADDR.
REQ-009 In IDLE, ctrl_start=1 with size=0 SHALL move to DONE and issue no AXI traffic.
REQ-010 ctrl_start SHALL be ignored in every state other than IDLE.
REQ-011 On entry to ADDR, the burst length SHALL be len = min(MAX_BURST_LEN, beats_left, (4096 - addr[11:0])/BPB), so that no burst crosses a 4 KB boundary.
REQ-012 In ADDR, the block SHALL drive arvalid=1, araddr=addr and arlen=len-1, and hold them stable until arready is sampled high; the AR handshake SHALL then move the FSM to DATA.
REQ-013 In DATA, the block SHALL drive rready = rd_tready, rd_tvalid = rvalid and rd_tdata = rdata combinationally; rready SHALL be 0 in every other state.
REQ-014 A beat is accepted when rvalid & rready; each accepted beat SHALL decrement beats_left by 1.
REQ-015 rd_tlast SHALL be 1 exactly when rd_tvalid=1 and beats_left=1.
REQ-016 The accepted beat carrying rlast=1 SHALL end the burst: addr SHALL advance by len*BPB, and the FSM SHALL go to ADDR if beats_left after the decrement is nonzero, otherwise to DONE.
REQ-017 If rlast disagrees with the internal beat count, the block SHALL still terminate the burst on rlast; behaviour after that is undefined but SHALL NOT deadlock the AR channel.
REQ-018 Only one burst SHALL be outstanding at any time.
REQ-019 DONE SHALL last exactly one cycle with ctrl_done=1, then return to IDLE.
REQ-020 ctrl_busy SHALL be 1 in ADDR and DATA, and 0 in IDLE and DONE.
REQ-021 Latency: the first arvalid SHALL occur in the cycle after the ctrl_start sample, and ctrl_done SHALL occur in the cycle after the final accepted beat.

Reset
REQ-022 While rstn=0, the block SHALL asynchronously force state=IDLE and arvalid, rready, rd_tvalid, rd_tlast, ctrl_busy and ctrl_done to 0, with araddr=0 and arlen=0.
REQ-023 Reset asserted mid-transfer SHALL abort the transfer with no ctrl_done; the bench SHALL also reset the AXI slave at the same time.

Verification
REQ-024 Single-burst case: offset=0x1000, size=64, MAX=16 -> one AR with araddr=0x1000 and arlen=15, 16 stream beats with rd_tlast on beat 16, and ctrl_done one cycle later.
REQ-025 Multi-burst case: offset=0x0, size=160 (40 beats) -> ARs with arlen 15, 15, 7 at araddr 0x0, 0x40, 0x80, and one rd_tlast on the final beat.
REQ-026 4 KB split case: offset=0x0FF8, size=32 -> an AR at 0x0FF8 with arlen=1, then an AR at 0x1000 with arlen=5.
REQ-027 Zero size and backpressure case: size=0 -> ctrl_done in the next cycle with no arvalid; rd_tready toggling 1/0 -> rready tracks it, and no beat is lost or duplicated.
REQ-028 Protocol case: arready held low for 5 cycles -> araddr and arlen stay stable; a ctrl_start while busy -> ignored; rstn pulsed low mid-DATA -> all outputs reach their reset values immediately, with no ctrl_done.
